// File: rtl/ddr3_iod_dly_ctrl_if.sv
// Request/completion and tap-readback port of ddr3_iod_dly_ctrl.
// Handshake: a request transfers on the FAB_CLK edge where REQ_VALID and REQ_READY are both 1;
// the master keeps REQ_LANE/LOAD/DIR/STEPS stable while REQ_VALID=1 and REQ_READY=0.
interface ddr3_iod_dly_ctrl_if #(
  parameter int NUM_LANES = 4
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic [LANE_W-1:0] REQ_LANE;
  logic              REQ_LOAD;
  logic              REQ_DIR;
  logic [7:0]        REQ_STEPS;
  logic              DONE;
  logic              DONE_ERR;
  logic [LANE_W-1:0] TAP_RD_LANE;
  logic [7:0]        TAP_RD_VAL;

  modport master (
    output REQ_VALID, REQ_LANE, REQ_LOAD, REQ_DIR, REQ_STEPS, TAP_RD_LANE,
    input  REQ_READY, DONE, DONE_ERR, TAP_RD_VAL
  );

  modport slave (
    input  REQ_VALID, REQ_LANE, REQ_LOAD, REQ_DIR, REQ_STEPS, TAP_RD_LANE,
    output REQ_READY, DONE, DONE_ERR, TAP_RD_VAL
  );
endinterface

// File: rtl/ddr3_iod_dly_ctrl.sv
// Dynamic delay-line sequencer for a group of DDR3 IOD lanes: one request at a time, settle after every pulse.
// DLY_CTRL_TAP_TRACK_EN builds per-lane tap counters, the TAP_MAX/0 pre-check and the TAP_RD_VAL readback.
module ddr3_iod_dly_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TAP_MAX       = 127,
  parameter int LOAD_TAP      = 1
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST_N,
  ddr3_iod_dly_ctrl_if.slave    req_if,
  output logic [NUM_LANES-1:0]  DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]  DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]  DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]  DELAY_LINE_OUT_OF_RANGE,
  output logic [2:0]            dbg_state_o
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MOVE   = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q;
  logic [LANE_W-1:0]   lane_q;
  logic                dir_q;
  logic                is_load_q;
  logic [7:0]          steps_q;
  logic [7:0]          settle_q;
  logic                ready_q;
  logic                done_q;
  logic                done_err_q;
  logic [NUM_LANES-1:0] load_pulse_q;
  logic [NUM_LANES-1:0] move_pulse_q;
  logic [NUM_LANES-1:0] dir_out_q;

  logic [NUM_LANES-1:0] acc_onehot_d;
  logic [NUM_LANES-1:0] sel_onehot_d;
  logic                 oor_sel_d;
  logic                 step_ok_acc_d;
  logic                 step_ok_chk_d;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i == int'(lane)) lane_onehot[i] = 1'b1;
    end
  endfunction

  assign acc_onehot_d = lane_onehot(req_if.REQ_LANE);
  assign sel_onehot_d = lane_onehot(lane_q);
  assign oor_sel_d    = |(DELAY_LINE_OUT_OF_RANGE & sel_onehot_d);

`ifdef DLY_CTRL_TAP_TRACK_EN
  logic [7:0] tap_q [NUM_LANES];
  logic [7:0] tap_acc_d;
  logic [7:0] tap_sel_d;
  logic [7:0] tap_rd_d;
  logic [7:0] tap_next_d;

  always_comb begin
    tap_acc_d = '0;
    tap_sel_d = '0;
    tap_rd_d  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i == int'(req_if.REQ_LANE))    tap_acc_d = tap_q[i];
      if (i == int'(lane_q))             tap_sel_d = tap_q[i];
      if (i == int'(req_if.TAP_RD_LANE)) tap_rd_d  = tap_q[i];
    end
    tap_next_d = dir_q ? (tap_sel_d + 8'd1) : (tap_sel_d - 8'd1);
  end

  // The pre-check is what keeps the counters from ever wrapping past TAP_MAX or below 0.
  assign step_ok_acc_d = req_if.REQ_DIR ? (tap_acc_d != 8'(TAP_MAX)) : (tap_acc_d != 8'd0);
  assign step_ok_chk_d = dir_q ? (tap_next_d != 8'(TAP_MAX)) : (tap_next_d != 8'd0);
  assign req_if.TAP_RD_VAL = tap_rd_d;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= 8'(LOAD_TAP);
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (i == int'(lane_q)) begin
          if (state_q == S_LOAD)                      tap_q[i] <= 8'(LOAD_TAP);
          else if (state_q == S_CHECK && !oor_sel_d)  tap_q[i] <= tap_next_d;
        end
      end
    end
  end
`else
  logic unused_track;

  assign step_ok_acc_d     = 1'b1;
  assign step_ok_chk_d     = 1'b1;
  assign req_if.TAP_RD_VAL = '0;
  assign unused_track      = ^{req_if.TAP_RD_LANE, dir_q, 8'(TAP_MAX), 8'(LOAD_TAP)};
`endif

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      dir_q        <= 1'b0;
      is_load_q    <= 1'b0;
      steps_q      <= '0;
      settle_q     <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      load_pulse_q <= '0;
      move_pulse_q <= '0;
      dir_out_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_if.REQ_VALID && ready_q) begin
            ready_q   <= 1'b0;
            lane_q    <= req_if.REQ_LANE;
            dir_q     <= req_if.REQ_DIR & ~req_if.REQ_LOAD;
            is_load_q <= req_if.REQ_LOAD;
            steps_q   <= req_if.REQ_STEPS;
            dir_out_q <= (req_if.REQ_DIR && !req_if.REQ_LOAD) ? acc_onehot_d : '0;
            if (req_if.REQ_LOAD) begin
              state_q      <= S_LOAD;
              load_pulse_q <= acc_onehot_d;
            end else if (req_if.REQ_STEPS == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!step_ok_acc_d) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
            end else begin
              state_q      <= S_MOVE;
              move_pulse_q <= acc_onehot_d;
            end
          end
        end
        S_LOAD: begin
          load_pulse_q <= '0;
          settle_q     <= 8'(SETTLE_CYCLES - 1);
          state_q      <= S_SETTLE;
        end
        S_MOVE: begin
          move_pulse_q <= '0;
          settle_q     <= 8'(SETTLE_CYCLES - 1);
          state_q      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == 8'd0) begin
            // A load has no range check, so it completes straight out of the settle window.
            if (is_load_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CHECK;
            end
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        S_CHECK: begin
          if (oor_sel_d) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            done_err_q <= 1'b1;
          end else begin
            steps_q <= steps_q - 8'd1;
            if (steps_q == 8'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!step_ok_chk_d) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
            end else begin
              state_q      <= S_MOVE;
              move_pulse_q <= sel_onehot_d;
            end
          end
        end
        S_DONE: begin
          done_q     <= 1'b0;
          done_err_q <= 1'b0;
          dir_out_q  <= '0;
          ready_q    <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_if.REQ_READY     = ready_q;
  assign req_if.DONE          = done_q;
  assign req_if.DONE_ERR      = done_err_q;
  assign DELAY_LINE_LOAD      = load_pulse_q;
  assign DELAY_LINE_MOVE      = move_pulse_q;
  assign DELAY_LINE_DIRECTION = dir_out_q;
  assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_ddr3_iod_dly_ctrl.sv
// Self-checking bench for ddr3_iod_dly_ctrl: directed vector table, hand-written reset sequence,
// and randomized requests checked against a step-by-step arithmetic model of the tap rules.
module tb_ddr3_iod_dly_ctrl;
  localparam int NL       = 4;
  localparam int S        = 4;
  localparam int STEP     = S + 2;
  localparam int TAP_MAX  = 127;
  localparam int LOAD_TAP = 1;
  localparam int RN       = 40;
`ifdef DLY_CTRL_TAP_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] dl_load, dl_move, dl_dir, dl_oor;
  logic [2:0]    dbg_state;

  ddr3_iod_dly_ctrl_if #(.NUM_LANES(NL)) req_if ();

  ddr3_iod_dly_ctrl #(
    .NUM_LANES(NL), .SETTLE_CYCLES(S), .TAP_MAX(TAP_MAX), .LOAD_TAP(LOAD_TAP)
  ) dut (
    .FAB_CLK                (clk),
    .ARST_N                 (rst_n),
    .req_if                 (req_if),
    .DELAY_LINE_LOAD        (dl_load),
    .DELAY_LINE_MOVE        (dl_move),
    .DELAY_LINE_DIRECTION   (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor),
    .dbg_state_o            (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int m_tap[NL];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lane; bit load; bit dir; int steps; int fault; bit glitch; bit chain;
    int e_done; bit e_err; int e_pulses; int e_tap;
  } vec_t;

  function automatic vec_t mk(int lane, bit load, bit dir, int steps, int fault, bit glitch,
                              bit chain, int e_done, bit e_err, int e_pulses, int e_tap);
    vec_t v;
    v.lane = lane; v.load = load; v.dir = dir; v.steps = steps; v.fault = fault;
    v.glitch = glitch; v.chain = chain; v.e_done = e_done; v.e_err = e_err;
    v.e_pulses = e_pulses; v.e_tap = e_tap;
    return v;
  endfunction

  // Reference: walk the requested steps one tap at a time under the tap/range rules.
  function automatic void predict(input vec_t v, output int e_done, output bit e_err,
                                  output int e_pulses, output int e_tap);
    e_err = 1'b0;
    e_pulses = 0;
    if (v.load) begin
      e_done = 2 + S;
      m_tap[v.lane] = LOAD_TAP;
    end else begin
      e_done = 1 + v.steps * STEP;
      for (int s = 1; s <= v.steps; s++) begin
        if (TRACK && ((v.dir && m_tap[v.lane] == TAP_MAX) || (!v.dir && m_tap[v.lane] == 0))) begin
          e_err = 1'b1;
          e_done = 1 + (s - 1) * STEP;
          break;
        end
        e_pulses++;
        if (s == v.fault) begin
          e_err = 1'b1;
          e_done = 1 + s * STEP;
          break;
        end
        m_tap[v.lane] += v.dir ? 1 : -1;
      end
    end
    e_tap = TRACK ? m_tap[v.lane] : 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_fields(input vec_t v, input bit valid);
    req_if.REQ_VALID = valid;
    req_if.REQ_LANE  = 2'(v.lane);
    req_if.REQ_LOAD  = v.load;
    req_if.REQ_DIR   = v.dir;
    req_if.REQ_STEPS = 8'(v.steps);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after DONE.
  task automatic run_req(input vec_t v, input vec_t nxt, input bit use_model);
    int e_done, e_pulses, e_tap, n, cyc, done_cyc, pulses, bad, load_cnt, dir_bad, rdy_bad;
    bit e_err, got_err, seen_done, sel_flag;
    logic [NL-1:0] oh;
    oh = '0;
    oh[v.lane] = 1'b1;
    predict(v, e_done, e_err, e_pulses, e_tap);
    if (!use_model) begin
      e_done = v.e_done; e_err = v.e_err; e_pulses = v.e_pulses; e_tap = v.e_tap;
    end
    exp_q.push_back(32'(e_done));
    exp_q.push_back(32'(e_err));
    exp_q.push_back(32'(e_pulses));
    exp_q.push_back(32'(e_tap));

    drive_fields(v, 1'b1);
    n = 0;
    while (req_if.REQ_READY !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(req_if.REQ_READY === 1'b1), 1);
    @(negedge clk);
    cyc = 1; done_cyc = -1; pulses = 0; bad = 0; load_cnt = 0; dir_bad = 0; rdy_bad = 0;
    got_err = 1'b0; seen_done = 1'b0;
    while (!seen_done && cyc <= 400) begin
      if (cyc == 1) drive_fields(nxt, v.chain);
      if (dl_move !== '0) begin
        if (dl_move === oh && !v.load) begin
          if (cyc != 1 + pulses * STEP) bad++;
          pulses++;
        end else bad++;
      end
      if (dl_load !== '0) begin
        if (dl_load === oh && v.load && cyc == 1) load_cnt++;
        else bad++;
      end
      if (!v.load && dl_dir !== (v.dir ? oh : '0)) dir_bad++;
      if (v.load && (dl_dir & ~oh) !== '0) dir_bad++;
      if (req_if.REQ_READY !== 1'b0) rdy_bad++;
      if (req_if.DONE === 1'b1) begin
        seen_done = 1'b1;
        done_cyc = cyc;
        got_err = req_if.DONE_ERR;
      end
      sel_flag = (v.fault > 0 && pulses >= v.fault) || (v.glitch && cyc == 3);
      dl_oor = (NL'($urandom) & ~oh) | (sel_flag ? oh : '0);
      @(negedge clk);
      cyc++;
    end
    dl_oor = '0;
    if (!seen_done) check("done_timeout", 0, 1);
    check("done_cycle", done_cyc, int'(exp_q.pop_front()));
    check("done_err", int'(got_err), int'(exp_q.pop_front()));
    check("move_pulses", pulses, int'(exp_q.pop_front()));
    check("stray_or_misplaced_pulse", bad, 0);
    if (v.load) check("load_pulse", load_cnt, 1);
    check("direction", dir_bad, 0);
    check("ready_low_busy", rdy_bad, 0);
    check("ready_after_done", int'(req_if.REQ_READY), 1);
    check("done_one_cycle", int'(req_if.DONE), 0);
    check("direction_idle", int'(dl_dir), 0);
    req_if.TAP_RD_LANE = 2'(v.lane);
    #1;
    check("tap_count", int'(req_if.TAP_RD_VAL), int'(exp_q.pop_front()));
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];
  vec_t rnd[RN+1];
  vec_t none;

  initial begin
    int ndone;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_fields(none, 1'b0);
    req_if.TAP_RD_LANE = '0;
    dl_oor = '0;
    for (int i = 0; i < NL; i++) m_tap[i] = LOAD_TAP;

    //            lane ld dir st flt gl ch  done                 err              pulses           tap
    tbl[0] = mk(2, 1, 0, 0, 0, 0, 0, 6,                   0,               0,               TRACK ? 1 : 0);
    tbl[1] = mk(0, 0, 1, 3, 0, 0, 1, 19,                  0,               3,               TRACK ? 4 : 0);
    tbl[2] = mk(1, 0, 0, 5, 0, 0, 0, TRACK ? 7 : 31,      TRACK,           TRACK ? 1 : 5,   0);
    tbl[3] = mk(3, 0, 1, 4, 2, 0, 0, 13,                  1,               2,               TRACK ? 2 : 0);
    tbl[4] = mk(0, 0, 1, 0, 0, 0, 1, 1,                   0,               0,               TRACK ? 4 : 0);
    tbl[5] = mk(0, 0, 0, 2, 0, 1, 0, 13,                  0,               2,               TRACK ? 2 : 0);
    tbl[6] = mk(0, 1, 1, 9, 0, 0, 0, 6,                   0,               0,               TRACK ? 1 : 0);
    tbl[7] = mk(1, 0, 0, 1, 0, 0, 0, TRACK ? 1 : 7,       TRACK,           TRACK ? 0 : 1,   0);

    for (int i = 0; i < RN + 1; i++) begin
      rnd[i].lane   = $urandom_range(0, NL - 1);
      rnd[i].load   = ($urandom_range(0, 7) == 0);
      rnd[i].dir    = $urandom_range(0, 1) == 1;
      rnd[i].steps  = $urandom_range(0, 6);
      rnd[i].fault  = ($urandom_range(0, 3) == 0 && rnd[i].steps > 0) ? $urandom_range(1, rnd[i].steps) : 0;
      rnd[i].glitch = (rnd[i].fault == 0) && ($urandom_range(0, 1) == 1);
      rnd[i].chain  = ($urandom_range(0, 1) == 1) && (i < RN - 1);
    end

    repeat (3) @(negedge clk);
    check("reset_ready", int'(req_if.REQ_READY), 1);
    check("reset_done", int'(req_if.DONE), 0);
    check("reset_pulses", int'({dl_load, dl_move, dl_dir}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      req_if.TAP_RD_LANE = 2'(i);
      #1;
      check("reset_tap", int'(req_if.TAP_RD_VAL), TRACK ? LOAD_TAP : 0);
    end
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_req(tbl[i], (i < 7) ? tbl[i+1] : none, 1'b0);
    for (int i = 0; i < RN; i++) run_req(rnd[i], rnd[i+1], 1'b1);

    // Asynchronous reset in the middle of a settle window.
    drive_fields(mk(2, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    drive_fields(none, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_dir", int'(dl_dir), 4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pulses_clear", int'({dl_load, dl_move, dl_dir}), 0);
    check("arst_ready", int'(req_if.REQ_READY), 1);
    check("arst_done", int'(req_if.DONE), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_if.DONE === 1'b1 || dl_move !== '0) ndone++;
    end
    check("no_done_after_arst", ndone, 0);
    for (int i = 0; i < NL; i++) begin
      m_tap[i] = LOAD_TAP;
      req_if.TAP_RD_LANE = 2'(i);
      #1;
      check("arst_tap", int'(req_if.TAP_RD_VAL), TRACK ? LOAD_TAP : 0);
    end
    @(negedge clk);
    run_req(mk(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), none, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
